// File: rtl/bu_s0_ctrl.sv
// Stage-0 radix-2 butterfly scheduler: buffers the first SPAN samples of each
// block and pairs sample i with sample i+SPAN as registered R0/R1 operands.
module bu_s0_ctrl #(
  parameter int P_WIDTH = 64,
  parameter int SPAN    = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_WIDTH-1:0] in_data,
  output logic [P_WIDTH-1:0] bu_r0,
  output logic [P_WIDTH-1:0] bu_r1,
  output logic               bu_valid,
  input  logic               bu_ready,
  output logic [ADDR_W-1:0]  pair_idx,
  output logic               blk_last,
  output logic [15:0]        blk_cnt
);

  // Handshake: a beat moves on a port in any cycle where its valid and ready
  // are both high at the rising clock edge; valid never waits on ready.

  typedef enum logic {FILL, PAIR} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SPAN - 1);

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  wr_ptr, wr_ptr_nx;
  logic [ADDR_W-1:0]  rd_ptr, rd_ptr_nx;
  logic [P_WIDTH-1:0] buf_mem [SPAN];
  logic               buf_we;
  logic               load;
  logic               issue;

  assign issue = bu_valid & bu_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nx;
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    in_ready  = 1'b1;
    buf_we    = 1'b0;
    load      = 1'b0;
    case (state)
      FILL: begin
        // A pending pair lives in the output register, so filling may proceed.
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we    = 1'b1;
          wr_ptr_nx = wr_ptr + 1'b1;
          if (wr_ptr == LAST) state_nx = PAIR;
        end
      end
      PAIR: begin
        in_ready = ~bu_valid | bu_ready;
        if (in_valid && in_ready) begin
          load      = 1'b1;
          rd_ptr_nx = rd_ptr + 1'b1;
          if (rd_ptr == LAST) state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  // Buffer contents need no reset; every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bu_r0    <= '0;
      bu_r1    <= '0;
      pair_idx <= '0;
      blk_last <= 1'b0;
      bu_valid <= 1'b0;
    end else if (load) begin
      bu_r0    <= buf_mem[rd_ptr];
      bu_r1    <= in_data;
      pair_idx <= rd_ptr;
      blk_last <= (rd_ptr == LAST);
      bu_valid <= 1'b1;
    end else if (issue) begin
      bu_valid <= 1'b0;
    end
  end

  // Counts blocks handed off downstream, so it advances on issue, not load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blk_cnt <= '0;
    else if (issue && blk_last) blk_cnt <= blk_cnt + 16'd1;
  end

endmodule

// File: tb/tb_bu_s0_ctrl.sv
// Self-checking bench for bu_s0_ctrl with SPAN=4: a reference model pushes the
// expected pair for each second-half sample; a monitor pops on every issue.
module tb_bu_s0_ctrl;

  localparam int W    = 64;
  localparam int SPAN = 4;
  localparam int AW   = 2;
  localparam int CW   = 2 * W + AW + 1;

  typedef logic [CW-1:0] chk_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [W-1:0]  bu_r0;
  logic [W-1:0]  bu_r1;
  logic          bu_valid;
  logic          bu_ready;
  logic [AW-1:0] pair_idx;
  logic          blk_last;
  logic [15:0]   blk_cnt;

  bu_s0_ctrl #(.P_WIDTH(W), .SPAN(SPAN), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .bu_r0    (bu_r0),
    .bu_r1    (bu_r1),
    .bu_valid (bu_valid),
    .bu_ready (bu_ready),
    .pair_idx (pair_idx),
    .blk_last (blk_last),
    .blk_cnt  (blk_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input chk_t got, input chk_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [CW-1:0] exp_q[$];
  logic [W-1:0]  half[SPAN];
  int            pos  = 0;
  int            sent = 0;
  logic [15:0]   exp_blk = '0;
  int            issue_cyc[$];

  task automatic model_accept(input logic [W-1:0] d);
    int i;
    sent++;
    if (pos < SPAN) begin
      half[pos] = d;
    end else begin
      i = pos - SPAN;
      exp_q.push_back({half[i], d, AW'(i), (i == SPAN - 1)});
      fork
        begin
          automatic logic [W-1:0] dd = d;
          @(negedge clk);
          check("lat_valid", chk_t'(bu_valid), chk_t'(1));
          check("lat_r1", chk_t'(bu_r1), chk_t'(dd));
        end
      join_none
    end
    pos = (pos + 1) % (2 * SPAN);
  endtask

  always @(negedge clk) begin
    if (!rst && bu_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_pair", chk_t'({bu_r0, bu_r1, pair_idx, blk_last}), chk_t'(0));
      end else begin
        check("pair", chk_t'({bu_r0, bu_r1, pair_idx, blk_last}), exp_q[0]);
        check("blk_cnt", chk_t'(blk_cnt), chk_t'(exp_blk));
        if (bu_ready) begin
          if (exp_q[0][0]) exp_blk <= exp_blk + 16'd1;
          void'(exp_q.pop_front());
          issue_cyc.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input int gap);
    int waited = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_wait", chk_t'(0), chk_t'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(d);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", chk_t'(exp_q.size()), chk_t'(0));
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] rnd;
  bit           rnd_done;

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    bu_ready = 1'b1;
    #1;
    check("rst_valid", chk_t'(bu_valid), chk_t'(0));
    check("rst_ready", chk_t'(in_ready), chk_t'(1));
    check("rst_outs", chk_t'({bu_r0, bu_r1, pair_idx, blk_last}), chk_t'(0));
    check("rst_blk", chk_t'(blk_cnt), chk_t'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming: 1..8 back to back, pairs must leave on consecutive cycles.
    issue_cyc.delete();
    for (int i = 1; i <= 8; i++) send(W'(i), 0);
    drain();
    check("stream_pairs", chk_t'(issue_cyc.size()), chk_t'(4));
    check("stream_no_bubble",
          chk_t'(issue_cyc.size() == 4 ? issue_cyc[3] - issue_cyc[0] : -1), chk_t'(3));
    check("stream_blk", chk_t'(blk_cnt), chk_t'(1));

    // Backpressure on the first pair of a block.
    for (int i = 1; i <= 5; i++) send(W'(i + 100), 0);
    bu_ready = 1'b0;
    fork
      begin
        for (int i = 6; i <= 8; i++) send(W'(i + 100), 0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", chk_t'(in_ready), chk_t'(0));
          check("bp_not_consumed", chk_t'(sent), chk_t'(13));
        end
        @(posedge clk);
        #1;
        bu_ready = 1'b1;
      end
    join
    drain();

    // Bubbles: in_valid alternates over two blocks of random samples.
    for (int i = 0; i < 16; i++) begin
      rnd = {$urandom, $urandom};
      send(rnd, 1);
    end
    drain();
    check("bubble_blk", chk_t'(blk_cnt), chk_t'(4));

    // Overlap: last pair held while the next block fills.
    for (int i = 1; i <= 8; i++) send(W'(i + 200), 0);
    bu_ready = 1'b0;
    for (int i = 9; i <= 12; i++) send(W'(i + 200), 0);
    @(negedge clk);
    check("ovl_held_last", chk_t'({bu_valid, blk_last}), chk_t'(2'b11));
    check("ovl_held_r1", chk_t'(bu_r1), chk_t'(W'(208)));
    @(posedge clk);
    #1;
    bu_ready = 1'b1;
    for (int i = 13; i <= 16; i++) send(W'(i + 200), 0);
    drain();

    // Random downstream backpressure with random input gaps.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          rnd = {$urandom, $urandom};
          send(rnd, $urandom_range(0, 2));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bu_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bu_ready = 1'b1;
    drain();
    check("rand_blk", chk_t'(blk_cnt), chk_t'(exp_blk));

    // Asynchronous reset while a pair is held.
    bu_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(W'(i + 300), 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", chk_t'(bu_valid), chk_t'(0));
    check("arst_blk", chk_t'(blk_cnt), chk_t'(0));
    check("arst_ready", chk_t'(in_ready), chk_t'(1));
    exp_q.delete();
    pos     = 0;
    exp_blk = '0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bu_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(W'(i + 400), 0);
    drain();
    check("post_rst_blk", chk_t'(blk_cnt), chk_t'(1));

    // Counter wrap from 65535.
    @(negedge clk);
    force dut.blk_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.blk_cnt;
    exp_blk = 16'hFFFF;
    for (int i = 1; i <= 8; i++) send(W'(i + 500), 0);
    drain();
    check("wrap_blk", chk_t'(blk_cnt), chk_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
